jtcontra_gfx_linebuf: RTL and testbench

//  Double-banked scan-line buffer sitting directly downstream of the 007121 tilemap engine.
//  - Write side: the tilemap writes the next line into bank 'line'.
//  - Read side: in step with the pixel clock, bank ~line is replayed to the colour mixer.
//  - Each location is cleared after it is read, so the tilemap only has to write opaque tiles.

---
 rtl/jtcontra_gfx_linebuf_pkg.sv | 19 +
 rtl/jtcontra_gfx_linebuf_ram.sv | 28 ++
 rtl/jtcontra_gfx_linebuf.sv | 118 +++++++++++
 tb/tb_jtcontra_gfx_linebuf.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/jtcontra_gfx_linebuf_pkg.sv
// rtl/jtcontra_gfx_linebuf_pkg.sv - shared constants, pixel-word fields and read FSM states for the line buffer
package jtcontra_gfx_pkg;

  localparam int LB_DW = 9;
  localparam int LB_AW = 9;
  localparam logic [LB_DW-1:0] BLANK_PXL = 9'h0;

  // pixel word = {scrwin, pal[3:0], col[3:0]}
  localparam int WIN_BIT = 8;
  localparam int PAL_LSB = 4;
  localparam int COL_LSB = 0;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_RD   = 2'd1,
    RD_CLR  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/jtcontra_gfx_linebuf_ram.sv
// rtl/jtcontra_gfx_linebuf_ram.sv - true dual-port line RAM; port A write-only, port B registered read plus write
module jtcontra_linebuf_ram #(
  parameter int DW = 9,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_q
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          b_wr_ok;

  // Tilemap data must never be lost to a clear of the same location
  always_comb b_wr_ok = b_we && !(a_we && (a_addr == b_addr));

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
    if (b_wr_ok) mem[b_addr] <= b_din;
    b_q <= mem[b_addr];
  end

endmodule

// File: rtl/jtcontra_gfx_linebuf.sv
// rtl/jtcontra_gfx_linebuf.sv - double-banked scan-line buffer after the 007121 tilemap
// Define JTCONTRA_LINEBUF_CLR_EN to clear each location after it is read during active video.
module jtcontra_gfx_linebuf #(
  parameter int DW = jtcontra_gfx_pkg::LB_DW,
  parameter int AW = jtcontra_gfx_pkg::LB_AW,
  parameter logic [DW-1:0] BLANK_PXL = jtcontra_gfx_pkg::BLANK_PXL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic          line,
  input  logic          wr_we,
  input  logic [AW:0]   wr_addr,
  input  logic [DW-1:0] wr_din,
  output logic [DW-1:0] pxl,
  output logic          pxl_win,
  output logic          opaque
);

  import jtcontra_gfx_pkg::*;

  rd_state_t     state_q, state_d;
  logic [AW:0]   rd_addr_q, rd_addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          lhbl_dly_q, lhbl_dly_d;
  logic [DW-1:0] pxl_q, pxl_d;
  logic          pxl_win_q, pxl_win_d;
  logic          opaque_q, opaque_d;

  logic [AW:0]   ram_b_addr;
  logic          ram_b_we;
  logic [DW-1:0] ram_q;

  jtcontra_linebuf_ram #(
    .DW(DW),
    .AW(AW + 1)
  ) u_ram (
    .clk    (clk),
    .a_we   (wr_we),
    .a_addr (wr_addr),
    .a_din  (wr_din),
    .b_we   (ram_b_we),
    .b_addr (ram_b_addr),
    .b_din  (BLANK_PXL),
    .b_q    (ram_q)
  );

  // The new address goes straight to the RAM so q is ready when RD samples it
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    ram_b_we   = 1'b0;
    ram_b_addr = rd_addr_q;
    case (state_q)
      RD_IDLE: begin
        if (pxl_cen) begin
          rd_addr_d  = {~line, hdump};
          ram_b_addr = {~line, hdump};
          state_d    = RD_RD;
        end
      end
      RD_RD: begin
        dout_d = ram_q;
`ifdef JTCONTRA_LINEBUF_CLR_EN
        state_d = LHBL ? RD_CLR : RD_IDLE;
`else
        state_d = RD_IDLE;
`endif
      end
      RD_CLR: begin
        ram_b_we = 1'b1;
        state_d  = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    lhbl_dly_d = lhbl_dly_q;
    pxl_d      = pxl_q;
    pxl_win_d  = pxl_win_q;
    opaque_d   = opaque_q;
    if (pxl_cen) begin
      lhbl_dly_d = LHBL;
      pxl_d      = lhbl_dly_q ? dout_q : BLANK_PXL;
      pxl_win_d  = pxl_d[WIN_BIT];
      opaque_d   = |pxl_d[COL_LSB +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      rd_addr_q  <= '0;
      dout_q     <= BLANK_PXL;
      lhbl_dly_q <= 1'b0;
      pxl_q      <= BLANK_PXL;
      pxl_win_q  <= 1'b0;
      opaque_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      lhbl_dly_q <= lhbl_dly_d;
      pxl_q      <= pxl_d;
      pxl_win_q  <= pxl_win_d;
      opaque_q   <= opaque_d;
    end
  end

  assign pxl     = pxl_q;
  assign pxl_win = pxl_win_q;
  assign opaque  = opaque_q;

endmodule

// File: tb/tb_jtcontra_gfx_linebuf.sv
// tb/tb_jtcontra_gfx_linebuf.sv - directed self-checking bench for jtcontra_gfx_linebuf
module tb_jtcontra_gfx_linebuf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b0;
  logic [8:0] hdump = '0;
  logic       line = 1'b0;
  logic       wr_we = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [8:0] wr_din = '0;
  logic [8:0] pxl;
  logic       pxl_win;
  logic       opaque;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtcontra_gfx_linebuf dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .LHBL    (LHBL),
    .hdump   (hdump),
    .line    (line),
    .wr_we   (wr_we),
    .wr_addr (wr_addr),
    .wr_din  (wr_din),
    .pxl     (pxl),
    .pxl_win (pxl_win),
    .opaque  (opaque)
  );

  // All tasks start and end on a falling edge
  task automatic cen_tick();
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wr(input logic [9:0] addr, input logic [8:0] din);
    wr_we = 1'b1;
    wr_addr = addr;
    wr_din = din;
    @(negedge clk);
    wr_we = 1'b0;
  endtask

  // First cen requests the column, second cen presents it on pxl
  task automatic read_col(input logic ln, input logic [8:0] col, input logic lh,
                          output logic [8:0] first_pxl);
    line = ln;
    hdump = col;
    LHBL = lh;
    cen_tick();
    first_pxl = pxl;
    hdump = 9'd511;
    cen_tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pxl !== 9'h000) begin n_fail++; $display("FAIL reset_pxl: got %h expected %h", pxl, 9'h000); end
    n_checks++;
    if (pxl_win !== 1'b0) begin n_fail++; $display("FAIL reset_win: got %b expected 0", pxl_win); end
    n_checks++;
    if (opaque !== 1'b0) begin n_fail++; $display("FAIL reset_opaque: got %b expected 0", opaque); end
    rst = 1'b0;
    @(negedge clk);
    wr({1'b0, 9'd511}, 9'h000);
    wr({1'b1, 9'd511}, 9'h000);
  endtask

  task automatic test_basic();
    logic [8:0] fp;
    line = 1'b1;
    wr({1'b1, 9'd20}, 9'h1A5);
    wr({1'b1, 9'd21}, 9'h0F0);
    wr({1'b1, 9'd22}, 9'h10C);
    wr({1'b0, 9'd20}, 9'h055);
    line = 1'b0;
    read_col(1'b0, 9'd20, 1'b1, fp);
    n_checks++;
    if (fp !== 9'h000) begin n_fail++; $display("FAIL basic_latency: got %h expected %h", fp, 9'h000); end
    n_checks++;
    if (pxl !== 9'h1A5) begin n_fail++; $display("FAIL basic_pxl: got %h expected %h", pxl, 9'h1A5); end
    n_checks++;
    if (pxl_win !== 1'b1) begin n_fail++; $display("FAIL basic_win: got %b expected 1", pxl_win); end
    n_checks++;
    if (opaque !== 1'b1) begin n_fail++; $display("FAIL basic_opaque: got %b expected 1", opaque); end
    read_col(1'b0, 9'd21, 1'b1, fp);
    n_checks++;
    if (pxl !== 9'h0F0) begin n_fail++; $display("FAIL transp_pxl: got %h expected %h", pxl, 9'h0F0); end
    n_checks++;
    if (pxl_win !== 1'b0) begin n_fail++; $display("FAIL transp_win: got %b expected 0", pxl_win); end
    n_checks++;
    if (opaque !== 1'b0) begin n_fail++; $display("FAIL transp_opaque: got %b expected 0", opaque); end
    read_col(1'b0, 9'd22, 1'b1, fp);
    n_checks++;
    if (pxl !== 9'h10C || pxl_win !== 1'b1 || opaque !== 1'b1) begin
      n_fail++;
      $display("FAIL win_pxl: got %h/%b/%b expected 10c/1/1", pxl, pxl_win, opaque);
    end
    read_col(1'b1, 9'd20, 1'b1, fp);
    n_checks++;
    if (pxl !== 9'h055) begin n_fail++; $display("FAIL bank0_pxl: got %h expected %h", pxl, 9'h055); end
  endtask

  task automatic test_clear();
    logic [8:0] fp;
    logic [8:0] exp_v;
`ifdef JTCONTRA_LINEBUF_CLR_EN
    exp_v = 9'h000;
`else
    exp_v = 9'h1A5;
`endif
    read_col(1'b0, 9'd20, 1'b1, fp);
    n_checks++;
    if (pxl !== exp_v) begin n_fail++; $display("FAIL reread_pxl: got %h expected %h", pxl, exp_v); end
    n_checks++;
    if (opaque !== (exp_v[3:0] != 4'h0)) begin n_fail++; $display("FAIL reread_opaque: got %b expected %b", opaque, exp_v[3:0] != 4'h0); end
  endtask

  task automatic test_hblank();
    logic [8:0] fp;
    logic [8:0] v;
    for (int i = 0; i < 64; i++) begin
      v = 9'h040 + 9'(i);
      wr({1'b1, 9'(i)}, v);
    end
    line = 1'b0;
    LHBL = 1'b0;
    for (int i = 0; i < 64; i++) begin
      hdump = 9'(i);
      cen_tick();
      if (i > 0) begin
        n_checks++;
        if (pxl !== 9'h000) begin n_fail++; $display("FAIL hblank_pxl[%0d]: got %h expected %h", i, pxl, 9'h000); end
      end
    end
    read_col(1'b0, 9'd5, 1'b1, fp);
    n_checks++;
    if (fp !== 9'h000) begin n_fail++; $display("FAIL hblank_tail: got %h expected %h", fp, 9'h000); end
    n_checks++;
    if (pxl !== 9'h045) begin n_fail++; $display("FAIL hblank_keep5: got %h expected %h", pxl, 9'h045); end
    read_col(1'b0, 9'd40, 1'b1, fp);
    n_checks++;
    if (pxl !== 9'h068) begin n_fail++; $display("FAIL hblank_keep40: got %h expected %h", pxl, 9'h068); end
  endtask

  task automatic test_collision();
    logic [8:0] fp;
    wr({1'b0, 9'd7}, 9'h033);
    line = 1'b1;
    LHBL = 1'b1;
    hdump = 9'd7;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    @(negedge clk);
    // Write lands on the same clock as the clear of {0,7}
    wr_we = 1'b1;
    wr_addr = {1'b0, 9'd7};
    wr_din = 9'h1C3;
    @(negedge clk);
    wr_we = 1'b0;
    repeat (2) @(negedge clk);
    read_col(1'b1, 9'd7, 1'b1, fp);
    n_checks++;
    if (fp !== 9'h033) begin n_fail++; $display("FAIL collide_old: got %h expected %h", fp, 9'h033); end
    n_checks++;
    if (pxl !== 9'h1C3) begin n_fail++; $display("FAIL collide_new: got %h expected %h", pxl, 9'h1C3); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] fp;
    wr({1'b0, 9'd30}, 9'h0AB);
    line = 1'b1;
    LHBL = 1'b1;
    hdump = 9'd30;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (pxl !== 9'h000 || pxl_win !== 1'b0 || opaque !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_out: got %h/%b/%b expected 000/0/0", pxl, pxl_win, opaque);
    end
    @(negedge clk);
    read_col(1'b1, 9'd30, 1'b1, fp);
    n_checks++;
    if (fp !== 9'h000) begin n_fail++; $display("FAIL midrst_latency: got %h expected %h", fp, 9'h000); end
    n_checks++;
    if (pxl !== 9'h0AB) begin n_fail++; $display("FAIL midrst_read: got %h expected %h", pxl, 9'h0AB); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear();
    test_hblank();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
